// File: rtl/uart_pkg.sv
// Shared UART types and line levels for the FIFO drain transmitter and the
// future receive side.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    WAIT,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by its single reader (master) and by the FIFO (slave).
interface fifo_uart_tx_if #(
  parameter int DATA_W = 8
);

  logic              fifo_r_en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;

  modport master (
    output fifo_r_en,
    input  fifo_empty,
    input  fifo_data
  );

  modport slave (
    input  fifo_r_en,
    output fifo_empty,
    output fifo_data
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Free-running bit-period counter with synchronous clear and a terminal-count
// flag; shared between the UART transmit and receive paths.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  output logic [$clog2(CLKS_PER_BIT)-1:0] cnt,
  output logic                            tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  assign tick = (cnt == TERMINAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one entry at a time and sends each byte as a UART 8N1
// frame on tx. Every output is a flop fed from the next-state decode.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en,
  fifo_uart_tx_if.master        fif,
  output logic                  tx,
  output logic                  busy,
  output logic                  byte_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] PRE_TERMINAL = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] LAST_BIT     = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);

  tx_state_e         state;
  tx_state_e         state_next;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  bit_idx_next;
  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic              tx_next;
  logic              r_en_next;
  logic              busy_next;
  logic              done_next;

  // Restarting the count on every state change keeps each bit a full period.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_next != state),
    .cnt   (cnt),
    .tick  (tick)
  );

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_idx_next = bit_idx;
    case (state)
      IDLE: begin
        if (tx_en && !fif.fifo_empty) begin
          state_next = POP;
        end
      end
      POP: begin
        state_next = WAIT;
      end
      WAIT: begin
        shreg_next = fif.fifo_data;
        state_next = START;
      end
      START: begin
        if (tick) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_next = shreg >> 1;
          if (bit_idx == LAST_BIT) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + IDX_ONE;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they line up with it after the edge.
  always_comb begin
    tx_next = STOP_BIT;
    case (state_next)
      START:   tx_next = START_BIT;
      DATA:    tx_next = shreg_next[0];
      default: tx_next = STOP_BIT;
    endcase
    r_en_next = (state_next == POP);
    busy_next = (state_next != IDLE);
    done_next = (state == STOP) && (cnt == PRE_TERMINAL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_idx       <= '0;
      tx            <= STOP_BIT;
      fif.fifo_r_en <= 1'b0;
      busy          <= 1'b0;
      byte_done     <= 1'b0;
    end else begin
      state         <= state_next;
      shreg         <= shreg_next;
      bit_idx       <= bit_idx_next;
      tx            <= tx_next;
      fif.fifo_r_en <= r_en_next;
      busy          <= busy_next;
      byte_done     <= done_next;
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the 16x8 byte FIFO. It pops bytes through the FIFO read port (r_en/empty/data_out) and serialises each byte as a UART 8N1 frame on a single tx line. It sits between the FIFO and the board pin and is the only reader of the FIFO.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit. Legal values are 2 or more. 868 gives 115200 baud at 100 MHz.
DATA_W, 8, byte width. Must match the FIFO data width.

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
tx_en  input  1  level; when low, no new frame starts
fifo_empty  input  1  FIFO empty flag
fifo_r_en  output  1  FIFO read strobe; one-cycle pulse per byte
fifo_data  input  DATA_W  FIFO data_out; registered, valid the cycle after the r_en edge
tx  output  1  serial line; idle high
busy  output  1  high from the fetch until the end of the stop bit
byte_done  output  1  one-cycle pulse in the last cycle of the stop bit

Behaviour:
- Interface (decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- All outputs are registered.
- Reset values: tx=1, fifo_r_en=0, busy=0, byte_done=0, state=IDLE, counters=0.
- Reset mid-frame: tx returns to 1 immediately and asynchronously. The in-flight byte is dropped. No re-read is issued.
- States: IDLE, POP, WAIT, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If tx_en=1 and fifo_empty=0 at a clk edge, go to POP.
- POP:
  - fifo_r_en=1 for exactly this one cycle; busy=1.
  - Always go to WAIT.
- WAIT:
  - fifo_r_en=0.
  - At the end of this cycle, capture fifo_data into the shift register and go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA:
  - tx=shreg[0] for CLKS_PER_BIT cycles per bit, LSB first.
  - Shift right after each bit.
  - After bit DATA_W-1, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - byte_done=1 in the final cycle, then go to IDLE.
- Timing:
  - Frame length is (DATA_W+2)*CLKS_PER_BIT cycles from the first start-bit cycle.
  - Latency from the IDLE decision edge to the first start-bit cycle is 2 cycles (POP, WAIT).
  - Back-to-back bytes leave 3 extra tx-high cycles between frames (IDLE, POP, WAIT). This is legal extra stop time.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1; the terminal count advances the bit.
  - Cleared on every state entry.
- bit_idx is $clog2(DATA_W) bits.
- tx_en is sampled only in IDLE. Dropping it mid-frame does not truncate the frame.
- fifo_empty is ignored outside IDLE. The FIFO guard makes the single pop safe.
- fifo_r_en is never asserted when fifo_empty was 1 at the decision edge.
- Exactly one pop per frame.

Decomposition:
- Package uart_pkg: the tx_state_e enum (IDLE, POP, WAIT, START, DATA, STOP), START_BIT=1'b0, STOP_BIT=1'b1.
- One natural sub-module, uart_baud_cnt:
  - Counter with clear and a terminal-count pulse, parameterised by CLKS_PER_BIT.
  - Reused later by the receive side.
- The FSM, shift register and bit index stay in fifo_uart_tx.

Test Plan:
1. Reset hold, then release with fifo_empty=1, tx_en=1 for 100 cycles -> tx=1, busy=0, fifo_r_en never high.
2. CLKS_PER_BIT=4, one byte 0xA5 in the FIFO, tx_en=1:
   - fifo_r_en pulses once for 1 cycle.
   - After 2 cycles tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles (40 cycles total).
   - byte_done pulses once, in cycle 40.
3. Bytes 0x00 and 0xFF queued back-to-back -> two frames of 40 cycles each, separated by exactly 3 tx-high cycles beyond the stop bit. There are exactly 2 r_en pulses, and the FIFO ends empty.
4. tx_en=0 with 3 bytes queued -> no r_en for 200 cycles. Raise tx_en -> all 3 bytes sent in order. Drop tx_en mid-way through the second frame -> that frame completes and the third is not started.
5. Assert rst_n=0 in the middle of data bit 3 of 0x3C -> tx=1 asynchronously within the same cycle and outputs take their reset values. After release with the FIFO holding 0x55, the next frame carries 0x55.
